// File: rtl/quad_counter_bank.sv
// quad_counter_bank: NC-channel quadrature encoder counter bank with coherent snapshot
// and byte-wise tristate readout. Define COUNTER_ERR_EN to add sticky illegal-transition flags.
module quad_counter_bank #(
  parameter int          NC        = 4,
  parameter int          SELW      = 2,
  parameter int          CW        = 16,
  parameter int          BSW       = 2,
  parameter int          FILTER    = 3,
  parameter logic [15:0] QUAD_FULL = 16'h0003
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*NC-1:0] q,
  input  logic            latch,
  input  logic            oe,
  input  logic [SELW-1:0] sel,
  input  logic [BSW-1:0]  byte_sel,
  output logic [7:0]      countout
);
  localparam int NB   = CW / 8;
  localparam int WW   = 5;
  localparam int WARM = FILTER + 2;

  logic [WW-1:0]                  warm;
  logic [NC-1:0][1:0]             s1, s2, stab, prev;
  logic [NC-1:0][FILTER-1:0][1:0] sh;
  logic [NC-1:0]                  sh_uniform, stab_vld, armed;
  logic [NC-1:0]                  step_fwd, step_rev;
  logic [NC-1:0][CW+1:0]          cnt;
  logic [NC-1:0][CW-1:0]          chval, shadow, shadow_nxt;
  logic [CW-1:0]                  sel_word;
  logic [7:0]                     rd, rd_nxt;

  function automatic logic [1:0] gray_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Blocks stable loads until the filter holds only post-reset samples, so the cleared
  // pipeline never masquerades as an encoder resting at 00.
  always_ff @(posedge clk) begin
    if (!rst) warm <= WW'(WARM);
    else if (warm != '0) warm <= warm - WW'(1);
  end

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      sh_uniform[i] = 1'b1;
      for (int j = 1; j < FILTER; j++)
        if (sh[i][j] != sh[i][0]) sh_uniform[i] = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      step_fwd[i] = 1'b0;
      step_rev[i] = 1'b0;
      if (armed[i] && (stab[i] != prev[i]) && ((stab[i] ^ prev[i]) != 2'b11)) begin
        if (gray_next(prev[i]) == stab[i]) step_fwd[i] = 1'b1;
        else                               step_rev[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1       <= '0;
      s2       <= '0;
      sh       <= '0;
      stab     <= '0;
      stab_vld <= '0;
      prev     <= '0;
      armed    <= '0;
      cnt      <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        s1[i]    <= q[2*i +: 2];
        s2[i]    <= s1[i];
        sh[i][0] <= s2[i];
        for (int j = 1; j < FILTER; j++) sh[i][j] <= sh[i][j-1];
        if ((warm == '0) && sh_uniform[i]) begin
          stab[i]     <= sh[i][0];
          stab_vld[i] <= 1'b1;
        end
        // First valid stable state only seeds prev; illegal jumps also just re-seed it.
        if (stab_vld[i]) begin
          prev[i]  <= stab[i];
          armed[i] <= 1'b1;
        end
        if (step_fwd[i])      cnt[i] <= cnt[i] + (CW+2)'(1);
        else if (step_rev[i]) cnt[i] <= cnt[i] - (CW+2)'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      chval[i]      = QUAD_FULL[i] ? cnt[i][CW-1:0] : cnt[i][CW+1:2];
      shadow_nxt[i] = latch ? chval[i] : shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) shadow <= '0;
    else      shadow <= shadow_nxt;
  end

`ifdef COUNTER_ERR_EN
  logic [NC-1:0] step_ill, err, err_shadow, err_shadow_nxt;

  always_comb begin
    for (int i = 0; i < NC; i++)
      step_ill[i] = armed[i] && ((stab[i] ^ prev[i]) == 2'b11);
  end

  // A latch hands the flag to the shadow; an illegal step in that same cycle re-arms it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err        <= '0;
      err_shadow <= '0;
    end else if (latch) begin
      err_shadow <= err;
      err        <= step_ill;
    end else begin
      err        <= err | step_ill;
    end
  end

  assign err_shadow_nxt = latch ? err : err_shadow;
`endif

  // Reads from the post-latch shadow so a byte read right after a latch is already coherent.
  always_comb begin
    rd_nxt   = '0;
    sel_word = '0;
    if (int'(sel) < NC) begin
      sel_word = shadow_nxt[sel];
      if (int'(byte_sel) < NB) rd_nxt = 8'(sel_word >> {byte_sel, 3'b000});
`ifdef COUNTER_ERR_EN
      else if (int'(byte_sel) == NB) rd_nxt = {7'b0, err_shadow_nxt[sel]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) rd <= '0;
    else      rd <= rd_nxt;
  end

  assign countout = oe ? rd : 'z;

endmodule

// File: tb/tb_quad_counter_bank.sv
// Bench for quad_counter_bank: two instances (FILTER 3 and FILTER 1) on shared inputs,
// table-driven directed reads plus randomized traffic against a window-based reference model.
module tb_quad_counter_bank;
  localparam int NC = 4;
  localparam int NB = 2;
`ifdef COUNTER_ERR_EN
  localparam logic [7:0] ERRB = 8'h01;
`else
  localparam logic [7:0] ERRB = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst, latch, oe;
  logic [7:0] q;
  logic [1:0] sel, byte_sel;
  tri1  [7:0] cout3, cout1;

  always #5 clk = ~clk;

  quad_counter_bank #(.NC(4), .SELW(2), .CW(16), .BSW(2), .FILTER(3), .QUAD_FULL(16'h0003)) dut (
    .clk(clk), .rst(rst), .q(q), .latch(latch), .oe(oe), .sel(sel), .byte_sel(byte_sel),
    .countout(cout3));

  quad_counter_bank #(.NC(4), .SELW(2), .CW(16), .BSW(2), .FILTER(1), .QUAD_FULL(16'h0003)) dut_f1 (
    .clk(clk), .rst(rst), .q(q), .latch(latch), .oe(oe), .sel(sel), .byte_sel(byte_sel),
    .countout(cout1));

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model: per channel, the counter at edge n sees the raw samples taken at
  // edges n-3-F .. n-4; a uniform window is an observed encoder position.
  logic [3:0]  qf = 4'b0011;
  logic [7:0]  hist [32];
  int          nedge;
  int          fd [2] = '{3, 1};
  logic [1:0]  m_state [2][4];
  bit          m_armed [2][4];
  int unsigned m_cnt [2][4];
  int unsigned m_shadow [2][4];
  bit          m_err [2][4];
  bit          m_errsh [2][4];
  logic [7:0]  m_rd [2];

  function automatic int gpos(logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned chval(int d, int i);
    if (qf[i]) return m_cnt[d][i] & 32'hFFFF;
    return (m_cnt[d][i] >> 2) & 32'hFFFF;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      nedge = 0;
      for (int d = 0; d < 2; d++) begin
        m_rd[d] = 8'h00;
        for (int i = 0; i < NC; i++) begin
          m_state[d][i] = 2'b00; m_armed[d][i] = 0; m_cnt[d][i] = 0;
          m_shadow[d][i] = 0; m_err[d][i] = 0; m_errsh[d][i] = 0;
        end
      end
    end else begin
      hist[nedge % 32] = q;
      for (int d = 0; d < 2; d++) begin
        if (latch)
          for (int i = 0; i < NC; i++) m_shadow[d][i] = chval(d, i);
        for (int i = 0; i < NC; i++) begin
          bit         ill;
          bit         uni;
          logic [1:0] v;
          logic [7:0] h;
          int         lo, df;
          ill = 0;
          lo  = nedge - 3 - fd[d];
          if (lo >= 0) begin
            h   = hist[(nedge - 4) % 32];
            v   = h[2*i +: 2];
            uni = 1;
            for (int k = lo; k <= nedge - 4; k++) begin
              h = hist[k % 32];
              if (h[2*i +: 2] != v) uni = 0;
            end
            if (uni) begin
              if (!m_armed[d][i]) begin
                m_armed[d][i] = 1;
              end else begin
                df = (gpos(v) - gpos(m_state[d][i]) + 4) % 4;
                if (df == 1)      m_cnt[d][i] = (m_cnt[d][i] + 1) & 32'h3FFFF;
                else if (df == 3) m_cnt[d][i] = (m_cnt[d][i] - 1) & 32'h3FFFF;
                else if (df == 2) ill = 1;
              end
              m_state[d][i] = v;
            end
          end
          if (latch) begin
            m_errsh[d][i] = m_err[d][i];
            m_err[d][i]   = ill;
          end else begin
            m_err[d][i] = m_err[d][i] | ill;
          end
        end
        if (int'(byte_sel) < NB)       m_rd[d] = 8'((m_shadow[d][sel] >> (8 * int'(byte_sel))) & 32'hFF);
        else if (int'(byte_sel) == NB) m_rd[d] = (ERRB != 8'h00) ? {7'b0, m_errsh[d][sel]} : 8'h00;
        else                           m_rd[d] = 8'h00;
      end
      nedge++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] e3, e1;
      e3 = oe ? m_rd[0] : 8'hFF;
      e1 = oe ? m_rd[1] : 8'hFF;
      checks++;
      if (cout3 !== e3) begin
        errors++;
        $display("FAIL model_f3 t=%0t got %02h want %02h", $time, cout3, e3);
      end
      checks++;
      if (cout1 !== e1) begin
        errors++;
        $display("FAIL model_f1 t=%0t got %02h want %02h", $time, cout1, e1);
      end
    end
  end

  typedef struct {
    int         s;
    int         b;
    logic [7:0] e3;
    logic [7:0] e1;
  } vec_t;
  vec_t vq[$];

  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         pos [4]  = '{2, 2, 2, 2};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h want %02h", name, got, exp);
    end
  endtask

  task automatic steps(int ch, int dir, int n, int hl);
    for (int k = 0; k < n; k++) begin
      pos[ch] = (pos[ch] + dir + 4) % 4;
      q[2*ch +: 2] = gray[pos[ch]];
      hold(hl);
    end
  endtask

  task automatic do_latch();
    latch = 1'b1;
    tick();
    latch = 1'b0;
  endtask

  task automatic run_vecs(string name);
    foreach (vq[k]) begin
      sel      = 2'(vq[k].s);
      byte_sel = 2'(vq[k].b);
      tick();
      check($sformatf("%s_f3 sel%0d byte%0d", name, vq[k].s, vq[k].b), cout3, vq[k].e3);
      check($sformatf("%s_f1 sel%0d byte%0d", name, vq[k].s, vq[k].b), cout1, vq[k].e1);
    end
    vq.delete();
  endtask

  initial begin
    rst = 1'b0; q = 8'hFF; latch = 1'b0; oe = 1'b1; sel = '0; byte_sel = '0;
    tick();
    chk_en = 1;
    hold(2);

    // Encoder resting at 11 through reset must not count.
    rst = 1'b1;
    hold(20);
    do_latch();
    for (int s = 0; s < 4; s++)
      for (int b = 0; b < 4; b++) vq.push_back('{s, b, 8'h00, 8'h00});
    run_vecs("arming");

    steps(0, 1, 10, 8);
    do_latch();
    vq.push_back('{0, 0, 8'h0A, 8'h0A});
    vq.push_back('{0, 1, 8'h00, 8'h00});
    vq.push_back('{1, 0, 8'h00, 8'h00});
    run_vecs("ch0_fwd10");

    steps(2, -1, 8, 8);
    do_latch();
    vq.push_back('{2, 0, 8'hFE, 8'hFE});
    vq.push_back('{2, 1, 8'hFF, 8'hFF});
    vq.push_back('{2, 3, 8'h00, 8'h00});
    run_vecs("ch2_rev8_x1");

    // Two-cycle glitches on ch1 A: filtered out at depth 3, net zero at depth 1.
    for (int g = 0; g < 3; g++) begin
      q[3] = 1'b0;
      hold(2);
      q[3] = 1'b1;
      hold(8);
    end
    do_latch();
    vq.push_back('{1, 0, 8'h00, 8'h00});
    vq.push_back('{1, 1, 8'h00, 8'h00});
    run_vecs("ch1_glitch");

    steps(1, 1, 1, 8);
    sel = 2'd1; byte_sel = 2'd0;
    tick();
    check("pre_latch_read_f3", cout3, 8'h00);
    do_latch();
    check("latch_during_read_f3", cout3, 8'h01);
    check("latch_during_read_f1", cout1, 8'h01);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    vq.push_back('{1, 0, 8'h00, 8'h00});
    vq.push_back('{0, 0, 8'h00, 8'h00});
    run_vecs("reset_mid");
    hold(10);
    steps(0, 1, 255, 4);
    hold(8);
    do_latch();
    vq.push_back('{0, 0, 8'hFF, 8'hFF});
    vq.push_back('{0, 1, 8'h00, 8'h00});
    run_vecs("ch0_ff");
    // Latch lands on the exact edge the depth-3 counter steps (depth 1 stepped 2 edges earlier).
    steps(0, 1, 1, 6);
    do_latch();
    vq.push_back('{0, 0, 8'hFF, 8'h00});
    vq.push_back('{0, 1, 8'h00, 8'h01});
    run_vecs("latch_same_cycle");
    do_latch();
    vq.push_back('{0, 0, 8'h00, 8'h00});
    vq.push_back('{0, 1, 8'h01, 8'h01});
    run_vecs("next_latch");

    steps(3, 1, 2, 8);
    do_latch();
    pos[3] = 2;
    q[7:6] = 2'b11;
    hold(8);
    do_latch();
    vq.push_back('{3, 2, ERRB, ERRB});
    vq.push_back('{3, 0, 8'h00, 8'h00});
    vq.push_back('{3, 1, 8'h00, 8'h00});
    run_vecs("ch3_illegal");
    do_latch();
    vq.push_back('{3, 2, 8'h00, 8'h00});
    run_vecs("ch3_err_clear");

    sel = 2'd0; byte_sel = 2'd1;
    tick();
    check("oe_on_f3", cout3, 8'h01);
    oe = 1'b0;
    #1;
    check("oe_off_f3", cout3, 8'hFF);
    check("oe_off_f1", cout1, 8'hFF);
    oe = 1'b1;
    #1;
    check("oe_back_f3", cout3, 8'h01);

    for (int it = 0; it < 3000; it++) begin
      int ch;
      ch = int'($urandom_range(0, 3));
      q[2*ch +: 2] = 2'($urandom_range(0, 3));
      latch    = ($urandom_range(0, 7) == 0);
      oe       = ($urandom_range(0, 5) != 0);
      sel      = 2'($urandom_range(0, 3));
      byte_sel = 2'($urandom_range(0, 3));
      rst      = ($urandom_range(0, 399) != 0);
      tick();
      latch = 1'b0;
      rst   = 1'b1;
      hold(int'($urandom_range(0, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
